sevenseg_mux: RTL and testbench
===============================

SEVENSEG_MUX -- requirements
Module: sevenseg_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 15: each digit slot lasts 2^REFRESH_DIV clocks, legal range 5..20.
REQ-003 Parameter BLINK_DIV, default 5: the blink phase toggles every 2^BLINK_DIV frames.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port display, input, 8*NUM_DIGITS bits: ASCII code per digit; bits [8i+7:8i] hold digit i.
REQ-007 Port decplace, input, max(1,$clog2(NUM_DIGITS)) bits: index of the digit that carries the decimal point.
REQ-008 Port dp_en, input, 1 bit: decimal point enable.
REQ-009 Port blink_mask, input, NUM_DIGITS bits: bit i set makes digit i blink.
REQ-010 Port brightness, input, 4 bits: duty level 0..15.
REQ-011 Port seg, output, 8 bits: cathodes {H,g,f,e,d,c,b,a}, active-low, registered.
REQ-012 Port an, output, NUM_DIGITS bits: anodes, active-low, registered.
REQ-013 Port frame_tick, output, 1 bit: registered one-cycle pulse once per full scan.

Function
REQ-014 A REFRESH_DIV-bit counter cnt SHALL increment every clock and wrap to 0.
- When cnt wraps, the digit index idx SHALL increment; from NUM_DIGITS-1 it SHALL wrap to 0.
REQ-015 Slot phase p = cnt[REFRESH_DIV-1 -: 4].
- While idx=i, an[NUM_DIGITS-1-i] SHALL be 0 only if 1 <= p <= brightness and the digit is not blink-blanked.
- All other anode bits SHALL be 1.
- p=0 is the ghost-suppression blank interval.
- brightness=0 gives all anodes off; brightness=15 gives 15/16 duty.
REQ-016 seg[6:0] SHALL decode display digit idx as follows; every other code SHALL map to 0xFE:
- 0x20->0xFF; 0x2D->0xBF; 0x5F->0xF7; 0x6F->0xA3.
- 0x30..0x39 -> C0,F9,A4,B0,99,92,82,F8,80,90.
- A->88, B->83, C->C6, D->A1, E->86, F->8E, G->82, H->89, K->8F, L->C7, P->8C, S->92.
- These codes are upper case, ASCII 0x41..0x53.
REQ-017 seg[7] SHALL be 0 when dp_en=1 and idx==decplace; otherwise seg[7] SHALL be the decoded H bit.
- A decplace value of NUM_DIGITS or more SHALL light no point.
REQ-018 seg and an SHALL be registered and reflect cnt/idx/inputs of the previous clock (latency 1).
- Input changes mid-slot SHALL take effect on the next clock.
REQ-019 frame_tick SHALL pulse high for exactly one cycle, in the cycle after idx wraps from NUM_DIGITS-1 to 0.
REQ-020 If brightness changes mid-slot, the new duty SHALL apply from the next clock; no slot is extended or skipped.

Reset
REQ-021 rstn=0 SHALL immediately, without a clock, force all of the following:
- cnt=0, idx=0, blink counter=0, blink phase=0.
- an = all ones, seg=0xFF, frame_tick=0.
REQ-022 Reset asserted mid-slot SHALL abort the scan; after release, scanning SHALL restart at digit 0 with a blank interval.

Configuration
REQ-023 Macro SEVENSEG_BLINK_EN.
- Defined: a BLINK_DIV-bit frame counter increments on each frame_tick and toggles the blink phase on wrap.
- Defined: while the blink phase is 1, every digit with blink_mask[i]=1 SHALL have its anode held at 1.
- Undefined: the blink logic is absent, blink_mask is ignored, and digits are never blink-blanked.

Verification
REQ-024 Scenario: NUM_DIGITS=4, REFRESH_DIV=5, brightness=15, display="0123".
- Required: an scans 0111,1011,1101,1110 with seg C0,F9,A4,B0.
- Required: each anode is low for 30 of 32 clocks; frame_tick pulses every 128 clocks.
REQ-025 Scenario: brightness=3.
- Required: each anode is low for exactly 6 clocks per 32-clock slot (p=1..3); brightness=0 gives an all ones.
REQ-026 Scenario: dp_en=1, decplace=2, display="5.5-".
- Required: seg=0x12 only during digit 2; 0x2E (unmapped) gives 0xFE; 0x2D gives 0xBF.
REQ-027 Scenario: SEVENSEG_BLINK_EN defined, BLINK_DIV=1, blink_mask=0001.
- Required: digit 0 is dark on alternate 2-frame periods while the other digits scan normally.
- Required: with the macro undefined, digit 0 is never dark.
REQ-028 Scenario: assert rstn=0 mid-slot, between clock edges.
- Required: an=1111 and seg=FF immediately.
- Required: after release, the first active anode is 0111, 3 clocks later.
REQ-029 Scenario: NUM_DIGITS=6.
- Required: idx wraps 5->0, an walks 011111..111110, and frame_tick pulses every 192 clocks.

Source files
------------

// File: rtl/sevenseg_mux.sv
// sevenseg_mux: scans NUM_DIGITS ASCII characters onto a common-anode seven-segment display with PWM brightness.
// Optional per-digit blinking is compiled in only when SEVENSEG_BLINK_EN is defined.
module sevenseg_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 15,
  parameter int BLINK_DIV   = 5,
  localparam int IDXW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [8*NUM_DIGITS-1:0] display,
  input  logic [IDXW-1:0]         decplace,
  input  logic                    dp_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [3:0]              brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  logic [REFRESH_DIV-1:0] r_cnt;
  logic [IDXW-1:0]        r_idx;
  logic                   w_slotEnd;
  logic                   w_frameEnd;
  logic [3:0]             w_phase;
  logic [7:0]             w_char;
  logic [7:0]             w_glyph;
  logic                   w_dp;
  logic                   w_blank;
  logic                   w_lit;
  logic [NUM_DIGITS-1:0]  w_an;

  assign w_slotEnd  = (r_cnt == '1);
  assign w_frameEnd = w_slotEnd && (r_idx == IDXW'(NUM_DIGITS - 1));
  assign w_phase    = r_cnt[REFRESH_DIV-1 -: 4];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      frame_tick <= 1'b0;
    end else begin
      r_cnt      <= r_cnt + REFRESH_DIV'(1);
      frame_tick <= w_frameEnd;
      if (w_slotEnd) begin
        r_idx <= w_frameEnd ? '0 : r_idx + IDXW'(1);
      end
    end
  end

`ifdef SEVENSEG_BLINK_EN
  logic [BLINK_DIV-1:0] r_blinkCnt;
  logic                 r_blinkPhase;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (frame_tick) begin
      r_blinkCnt <= r_blinkCnt + BLINK_DIV'(1);
      if (r_blinkCnt == '1) begin
        r_blinkPhase <= ~r_blinkPhase;
      end
    end
  end

  always_comb begin
    w_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_blank = r_blinkPhase & blink_mask[i];
      end
    end
  end
`else
  logic w_unusedBlink;
  assign w_unusedBlink = ^{blink_mask, 1'(BLINK_DIV)};
  assign w_blank       = 1'b0;
`endif

  // Loop-based select keeps non-power-of-two digit counts free of out-of-range part selects.
  always_comb begin
    w_char = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_char = display[8*i +: 8];
      end
    end
  end

  always_comb begin
    unique case (w_char)
      8'h20:   w_glyph = 8'hFF;
      8'h2D:   w_glyph = 8'hBF;
      8'h5F:   w_glyph = 8'hF7;
      8'h6F:   w_glyph = 8'hA3;
      8'h30:   w_glyph = 8'hC0;
      8'h31:   w_glyph = 8'hF9;
      8'h32:   w_glyph = 8'hA4;
      8'h33:   w_glyph = 8'hB0;
      8'h34:   w_glyph = 8'h99;
      8'h35:   w_glyph = 8'h92;
      8'h36:   w_glyph = 8'h82;
      8'h37:   w_glyph = 8'hF8;
      8'h38:   w_glyph = 8'h80;
      8'h39:   w_glyph = 8'h90;
      8'h41:   w_glyph = 8'h88;
      8'h42:   w_glyph = 8'h83;
      8'h43:   w_glyph = 8'hC6;
      8'h44:   w_glyph = 8'hA1;
      8'h45:   w_glyph = 8'h86;
      8'h46:   w_glyph = 8'h8E;
      8'h47:   w_glyph = 8'h82;
      8'h48:   w_glyph = 8'h89;
      8'h4B:   w_glyph = 8'h8F;
      8'h4C:   w_glyph = 8'hC7;
      8'h50:   w_glyph = 8'h8C;
      8'h53:   w_glyph = 8'h92;
      default: w_glyph = 8'hFE;
    endcase
  end

  // Out-of-range decimal point positions must never match a scanned digit.
  assign w_dp  = dp_en && (32'(decplace) < 32'(NUM_DIGITS)) && (decplace == r_idx);
  assign w_lit = (w_phase != 4'd0) && (w_phase <= brightness) && !w_blank;

  always_comb begin
    w_an = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_lit && (r_idx == IDXW'(i))) begin
        w_an[NUM_DIGITS-1-i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= {w_glyph[7] & ~w_dp, w_glyph[6:0]};
      an  <= w_an;
    end
  end

endmodule

// File: tb/tb_sevenseg_mux.sv
// tb_sevenseg_mux: checks a 4-digit and a 6-digit sevenseg_mux against a time-based reference model.
// Blink expectations follow SEVENSEG_BLINK_EN exactly as the design is compiled.
`timescale 1ns/1ps
module tb_sevenseg_mux;
  localparam int R    = 5;
  localparam int B    = 1;
  localparam int SLOT = 1 << R;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] ch [8];
  logic [2:0] dp;
  logic       dpEn;
  logic [7:0] mask;
  logic [3:0] bright;
  logic [7:0] seg4, seg6;
  logic [3:0] an4;
  logic [5:0] an6;
  logic       ft4, ft6;
  logic [7:0] eSeg4, eSeg6, eAn4, eAn6;
  logic       eFt4, eFt6;
  int          checks = 0;
  int          errors = 0;
  int unsigned k = 0;

  always #5 clk = ~clk;

  sevenseg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(R), .BLINK_DIV(B)) dut4 (
    .clk(clk), .rstn(rstn), .display({ch[3], ch[2], ch[1], ch[0]}),
    .decplace(dp[1:0]), .dp_en(dpEn), .blink_mask(mask[3:0]), .brightness(bright),
    .seg(seg4), .an(an4), .frame_tick(ft4));

  sevenseg_mux #(.NUM_DIGITS(6), .REFRESH_DIV(R), .BLINK_DIV(B)) dut6 (
    .clk(clk), .rstn(rstn), .display({ch[5], ch[4], ch[3], ch[2], ch[1], ch[0]}),
    .decplace(dp), .dp_en(dpEn), .blink_mask(mask[5:0]), .brightness(bright),
    .seg(seg6), .an(an6), .frame_tick(ft6));

  function automatic logic [7:0] refGlyph(input logic [7:0] c);
    logic [7:0] digits [10];
    digits = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (c >= 8'h30 && c <= 8'h39) return digits[c - 8'h30];
    case (c)
      8'h20: return 8'hFF;
      8'h2D: return 8'hBF;
      8'h5F: return 8'hF7;
      8'h6F: return 8'hA3;
      "A":   return 8'h88;
      "B":   return 8'h83;
      "C":   return 8'hC6;
      "D":   return 8'hA1;
      "E":   return 8'h86;
      "F":   return 8'h8E;
      "G":   return 8'h82;
      "H":   return 8'h89;
      "K":   return 8'h8F;
      "L":   return 8'hC7;
      "P":   return 8'h8C;
      "S":   return 8'h92;
      default: return 8'hFE;
    endcase
  endfunction

  // Output after the kk-th edge since reset reflects the scan position reached after kk-1 edges.
  function automatic void model(input int n, input int unsigned kk,
                                output logic [7:0] eSeg, output logic [7:0] eAn, output logic eFt);
    int unsigned m, cnt, p, idx, dpv;
    bit blank, lit;
    m     = kk - 1;
    cnt   = m % SLOT;
    p     = cnt >> (R - 4);
    idx   = (m / SLOT) % n;
    blank = 1'b0;
`ifdef SEVENSEG_BLINK_EN
    begin
      int unsigned frames;
      frames = (m == 0) ? 0 : (m - 1) / (n * SLOT);
      blank  = (((frames >> B) & 1) == 1) && (mask[idx] == 1'b1);
    end
`endif
    lit = (p >= 1) && (p <= bright) && !blank;
    eAn = 8'hFF;
    if (lit) eAn[n-1-idx] = 1'b0;
    eSeg = refGlyph(ch[idx]);
    dpv  = (n == 4) ? 32'(dp[1:0]) : 32'(dp);
    if (dpEn && dpv < n && dpv == idx) eSeg[7] = 1'b0;
    eFt = (kk % (n * SLOT)) == 0;
  endfunction

  function automatic string report();
    return $sformatf("k=%0d got seg4=%h an4=%b ft4=%b seg6=%h an6=%b ft6=%b, expected seg4=%h an4=%b ft4=%b seg6=%h an6=%b ft6=%b",
                     k, seg4, an4, ft4, seg6, an6, ft6, eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    model(4, k, eSeg4, eAn4, eFt4);
    model(6, k, eSeg6, eAn6, eFt6);
  endtask

  task automatic pulseReset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) ch[i] = 8'h20;
    dp = 3'd0; dpEn = 1'b0; mask = 8'h00; bright = 4'd15;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({seg4, an4, ft4, seg6, an6, ft6} !== {8'hFF, 4'hF, 1'b0, 8'hFF, 6'h3F, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_async got seg4=%h an4=%b ft4=%b seg6=%h an6=%b ft6=%b, expected FF/1111/0", seg4, an4, ft4, seg6, an6, ft6);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({seg4, an4, ft4, seg6, an6, ft6} !== {8'hFF, 4'hF, 1'b0, 8'hFF, 6'h3F, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_held got seg4=%h an4=%b seg6=%h an6=%b, expected FF/1111", seg4, an4, seg6, an6);
    end
    rstn = 1'b1;
    k = 0;
  endtask

  task automatic test_scan();
    logic [7:0] segTab [4];
    int low0, ft4n, ft6n, d;
    segTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    for (int i = 0; i < 8; i++) ch[i] = 8'h30 + 8'(i);
    bright = 4'd15; dpEn = 1'b0; dp = 3'd0; mask = 8'h00;
    pulseReset();
    low0 = 0; ft4n = 0; ft6n = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++;
      if ({seg4, an4, ft4, seg6, an6, ft6} !== {eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6}) begin
        errors++;
        $display("[TB] FAIL scan %s", report());
      end
      if (k <= 32 && an4[3] == 1'b0) low0++;
      ft4n += int'(ft4);
      ft6n += int'(ft6);
      if (k < 128 && k % 32 == 3) begin
        d = int'(k / 32);
        checks++;
        if (an4 !== ~(4'b1000 >> d) || seg4 !== segTab[d]) begin
          errors++;
          $display("[TB] FAIL scan_digit%0d got an4=%b seg4=%h, expected an4=%b seg4=%h", d, an4, seg4, ~(4'b1000 >> d), segTab[d]);
        end
      end
    end
    checks++;
    if (low0 != 30 || ft4n != 2 || ft6n != 1) begin
      errors++;
      $display("[TB] FAIL scan_duty got low=%0d ticks4=%0d ticks6=%0d, expected 30/2/1", low0, ft4n, ft6n);
    end
  endtask

  task automatic test_brightness();
    int low0, anyOn;
    bright = 4'd3;
    pulseReset();
    low0 = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      checks++;
      if ({seg4, an4, ft4, seg6, an6, ft6} !== {eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6}) begin
        errors++;
        $display("[TB] FAIL bright3 %s", report());
      end
      if (k <= 32 && an4[3] == 1'b0) low0++;
    end
    checks++;
    if (low0 != 6) begin
      errors++;
      $display("[TB] FAIL bright3_duty got %0d low clocks, expected 6", low0);
    end
    bright = 4'd0;
    anyOn = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (an4 !== 4'hF || an6 !== 6'h3F) anyOn++;
    end
    checks++;
    if (anyOn != 0) begin
      errors++;
      $display("[TB] FAIL bright0 got %0d cycles with a lit anode, expected 0", anyOn);
    end
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 3) == 0) bright = 4'($urandom);
      tick();
      checks++;
      if ({seg4, an4, ft4, seg6, an6, ft6} !== {eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6}) begin
        errors++;
        $display("[TB] FAIL bright_change %s", report());
      end
    end
  endtask

  task automatic test_decimal();
    logic [7:0] segDp [4];
    int d, dots6;
    segDp = '{8'h92, 8'hFE, 8'h12, 8'hBF};
    ch[0] = "5"; ch[1] = "."; ch[2] = "5"; ch[3] = "-"; ch[4] = "5"; ch[5] = "8";
    bright = 4'd15; dpEn = 1'b1; dp = 3'd2; mask = 8'h00;
    pulseReset();
    for (int i = 0; i < 192; i++) begin
      tick();
      checks++;
      if ({seg4, an4, ft4, seg6, an6, ft6} !== {eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6}) begin
        errors++;
        $display("[TB] FAIL decimal %s", report());
      end
      if (k <= 128 && (k - 1) % 32 == 10) begin
        d = int'((k - 1) / 32);
        checks++;
        if (seg4 !== segDp[d]) begin
          errors++;
          $display("[TB] FAIL decimal_digit%0d got seg4=%h, expected %h", d, seg4, segDp[d]);
        end
      end
    end
    dp = 3'd6;
    dots6 = 0;
    for (int i = 0; i < 192; i++) begin
      tick();
      if (seg6[7] == 1'b0) dots6++;
    end
    checks++;
    if (dots6 != 0) begin
      errors++;
      $display("[TB] FAIL decimal_out_of_range got %0d cycles with point lit, expected 0", dots6);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [26];
    pool = '{8'h20, 8'h2D, 8'h5F, 8'h6F, "0", "1", "2", "3", "4", "5", "6", "7", "8", "9",
             "A", "B", "C", "D", "E", "F", "G", "H", "K", "L", "P", "S"};
    for (int burst = 0; burst < 8; burst++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) ch[i] = 8'($urandom);
        else ch[i] = pool[$urandom_range(0, 25)];
      end
      dp = 3'($urandom); dpEn = 1'($urandom); mask = 8'($urandom); bright = 4'($urandom);
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 15) == 0) bright = 4'($urandom);
        if ($urandom_range(0, 31) == 0) dp = 3'($urandom);
        tick();
        checks++;
        if ({seg4, an4, ft4, seg6, an6, ft6} !== {eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6}) begin
          errors++;
          $display("[TB] FAIL random %s", report());
        end
      end
    end
  endtask

  task automatic test_blink();
    bit lit0 [8];
    int dark, expDark, f;
    for (int i = 0; i < 8; i++) begin
      ch[i] = 8'h30 + 8'(i);
      lit0[i] = 1'b0;
    end
    bright = 4'd15; dpEn = 1'b0; mask = 8'h01;
    pulseReset();
    for (int i = 0; i < 1024; i++) begin
      tick();
      checks++;
      if ({seg4, an4, ft4, seg6, an6, ft6} !== {eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6}) begin
        errors++;
        $display("[TB] FAIL blink %s", report());
      end
      f = int'((k - 1) / 128);
      if (an4[3] == 1'b0) lit0[f] = 1'b1;
    end
    dark = 0;
    for (int i = 0; i < 8; i++) if (!lit0[i]) dark++;
`ifdef SEVENSEG_BLINK_EN
    expDark = 4;
`else
    expDark = 0;
`endif
    checks++;
    if (dark != expDark) begin
      errors++;
      $display("[TB] FAIL blink_frames got %0d dark frames for digit 0, expected %0d", dark, expDark);
    end
  endtask

  task automatic test_midreset();
    mask = 8'h00; bright = 4'd15;
    for (int i = 0; i < 70; i++) tick();
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({seg4, an4, ft4, seg6, an6, ft6} !== {8'hFF, 4'hF, 1'b0, 8'hFF, 6'h3F, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_async got seg4=%h an4=%b seg6=%h an6=%b, expected FF/1111", seg4, an4, seg6, an6);
    end
    #2 rstn = 1'b1;
    k = 0;
    tick();
    tick();
    checks++;
    if (an4 !== 4'hF || an6 !== 6'h3F) begin
      errors++;
      $display("[TB] FAIL midreset_blank got an4=%b an6=%b, expected 1111/111111", an4, an6);
    end
    tick();
    checks++;
    if (an4 !== 4'b0111 || an6 !== 6'b011111) begin
      errors++;
      $display("[TB] FAIL midreset_first got an4=%b an6=%b, expected 0111/011111", an4, an6);
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++;
      if ({seg4, an4, ft4, seg6, an6, ft6} !== {eSeg4, eAn4[3:0], eFt4, eSeg6, eAn6[5:0], eFt6}) begin
        errors++;
        $display("[TB] FAIL midreset_scan %s", report());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_decimal();
    test_random();
    test_blink();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
